// File: rtl/alu_mux_pipe.sv
// Purpose: N:1 ALU operand selector, registered behind a valid/ready handshake with a 2-entry skid.
// Latency: 1 cycle from accept to dout when the main register is free or draining.
// Backpressure: in_ready is registered (!skid_valid); one extra beat parks in the skid while dout stalls.
// Optional feature macro: MUX_SEL_ERR_EN (out-of-range sel flags sel_err and zeroes dout).
module alu_mux_pipe #(
    parameter  int WIDTH  = 32,
    parameter  int NUM_IN = 4,
    localparam int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*NUM_IN-1:0] din,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        dout,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // Main output register and single-entry skid register
    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_dat_q, main_dat_d;
    logic             main_err_q, main_err_d;
    logic             skid_vld_q, skid_vld_d;
    logic [WIDTH-1:0] skid_dat_q, skid_dat_d;
    logic             skid_err_q, skid_err_d;

    // Selected beat and its error flag, before registering
    logic [WIDTH-1:0] sel_dat;
    logic             sel_hit;
    logic             beat_err;

    logic             accept;
    logic             main_free;

    // Input selection; sel_hit is low only for sel >= NUM_IN (non-power-of-2 NUM_IN)
    always_comb begin
        sel_hit  = 1'b0;
        sel_dat  = '0;
        beat_err = 1'b0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (sel == SEL_W'(i)) begin
                sel_hit = 1'b1;
                sel_dat = din[i*WIDTH +: WIDTH];
            end
        end
`ifdef MUX_SEL_ERR_EN
        // Out-of-range select: emit zero data and flag this beat only
        beat_err = !sel_hit;
`else
        // Out-of-range select falls back to input 0, no error reported
        if (!sel_hit) begin
            sel_dat = din[WIDTH-1:0];
        end
`endif
    end

    assign accept    = in_valid && !skid_vld_q;
    assign main_free = !main_vld_q || out_ready;

    // Next-state: skid has priority into main to keep order; new beats go to skid only on stall
    always_comb begin
        main_vld_d = main_vld_q;
        main_dat_d = main_dat_q;
        main_err_d = main_err_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        skid_err_d = skid_err_q;
        if (main_free) begin
            if (skid_vld_q) begin
                main_vld_d = 1'b1;
                main_dat_d = skid_dat_q;
                main_err_d = skid_err_q;
                skid_vld_d = 1'b0;
            end else if (accept) begin
                main_vld_d = 1'b1;
                main_dat_d = sel_dat;
                main_err_d = beat_err;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = sel_dat;
            skid_err_d = beat_err;
        end
    end

    // State registers with synchronous reset discarding any held beats
    always_ff @(posedge clk) begin
        if (rst) begin
            main_vld_q <= 1'b0;
            main_dat_q <= '0;
            main_err_q <= 1'b0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
            skid_err_q <= 1'b0;
        end else begin
            main_vld_q <= main_vld_d;
            main_dat_q <= main_dat_d;
            main_err_q <= main_err_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
            skid_err_q <= skid_err_d;
        end
    end

    assign in_ready  = !skid_vld_q;
    assign out_valid = main_vld_q;
    assign dout      = main_dat_q;
    assign sel_err   = main_err_q;

endmodule

// File: tb/tb_alu_mux_pipe.sv
// Directed bench for alu_mux_pipe: reset, streaming, backpressure, mid-stream reset,
// NUM_IN=3 out-of-range select (both macro builds), then a random handshake run vs a queue model.
// Inputs change 1 ns after the rising edge; outputs are checked at that same point.
module tb_alu_mux_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // NUM_IN=4 instance
    logic [127:0] din4;
    logic [1:0]   sel4;
    logic         iv4, or4;
    logic         ir4, ov4, err4;
    logic [31:0]  dout4;

    // NUM_IN=3 instance
    logic [95:0]  din3;
    logic [1:0]   sel3;
    logic         iv3, or3;
    logic         ir3, ov3, err3;
    logic [31:0]  dout3;

    alu_mux_pipe #(.WIDTH(32), .NUM_IN(4)) u4 (
        .clk(clk), .rst(rst), .din(din4), .sel(sel4), .in_valid(iv4), .in_ready(ir4),
        .dout(dout4), .out_valid(ov4), .out_ready(or4), .sel_err(err4)
    );

    alu_mux_pipe #(.WIDTH(32), .NUM_IN(3)) u3 (
        .clk(clk), .rst(rst), .din(din3), .sel(sel3), .in_valid(iv3), .in_ready(ir3),
        .dout(dout3), .out_valid(ov3), .out_ready(or3), .sel_err(err3)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] q[$];
    logic [31:0] prev_dout;
    logic        prev_stall, acc, emi, pend;

    initial begin
        rst  = 1'b1;
        din4 = {32'hDEADBEEF, 32'h55555555, 32'hAAAAAAAA, 32'h12345678};
        sel4 = 2'd2; iv4 = 1'b1; or4 = 1'b1;
        din3 = {32'hC0FFEE00, 32'h0BADF00D, 32'h11111111};
        sel3 = 2'd1; iv3 = 1'b1; or3 = 1'b0;

        // Reset held two cycles with active inputs
        tick(); tick();
        chk("rst_ov", 32'(ov4), 32'd0);
        chk("rst_dout", dout4, 32'd0);
        chk("rst_err", 32'(err4), 32'd0);
        chk("rst_ov3", 32'(ov3), 32'd0);
        rst = 1'b0; iv4 = 1'b0; iv3 = 1'b0; or3 = 1'b1;
        tick();
        chk("rst_ir", 32'(ir4), 32'd1);
        chk("rst_idle_ov", 32'(ov4), 32'd0);

        // Streaming sel 0..3, one beat per cycle, one cycle latency
        iv4 = 1'b1; or4 = 1'b1; sel4 = 2'd0;
        tick(); chk("str0", dout4, 32'h12345678); chk("str0_ov", 32'(ov4), 32'd1);
        sel4 = 2'd1;
        tick(); chk("str1", dout4, 32'hAAAAAAAA); chk("str1_ir", 32'(ir4), 32'd1);
        sel4 = 2'd2;
        tick(); chk("str2", dout4, 32'h55555555);
        sel4 = 2'd3;
        tick(); chk("str3", dout4, 32'hDEADBEEF); chk("str3_ov", 32'(ov4), 32'd1);
        iv4 = 1'b0;
        tick(); chk("str_end_ov", 32'(ov4), 32'd0);

        // NUM_IN=3: out-of-range sel=3, then in-range beats
        iv3 = 1'b1; sel3 = 2'd3;
        tick();
        chk("n3_oor_ov", 32'(ov3), 32'd1);
`ifdef MUX_SEL_ERR_EN
        chk("n3_oor_dout", dout3, 32'd0);
        chk("n3_oor_err", 32'(err3), 32'd1);
`else
        chk("n3_oor_dout", dout3, 32'h11111111);
        chk("n3_oor_err", 32'(err3), 32'd0);
`endif
        sel3 = 2'd2;
        tick(); chk("n3_s2_dout", dout3, 32'hC0FFEE00); chk("n3_s2_err", 32'(err3), 32'd0);
        sel3 = 2'd1;
        tick(); chk("n3_s1_dout", dout3, 32'h0BADF00D); chk("n3_s1_err", 32'(err3), 32'd0);
        iv3 = 1'b0;
        tick(); chk("n3_end_ov", 32'(ov3), 32'd0);

        // Backpressure: first beat to main, second to skid, third refused
        or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd0;
        tick(); chk("bp_d0", dout4, 32'h12345678); chk("bp_ir0", 32'(ir4), 32'd1);
        sel4 = 2'd1;
        tick(); chk("bp_hold1", dout4, 32'h12345678); chk("bp_ir1", 32'(ir4), 32'd0);
        sel4 = 2'd2;
        tick(); chk("bp_hold2", dout4, 32'h12345678); chk("bp_ir2", 32'(ir4), 32'd0);
        chk("bp_ov2", 32'(ov4), 32'd1);
        iv4 = 1'b0; or4 = 1'b1;
        tick(); chk("bp_d1", dout4, 32'hAAAAAAAA); chk("bp_ov3", 32'(ov4), 32'd1);
        chk("bp_ir3", 32'(ir4), 32'd1);
        tick(); chk("bp_empty", 32'(ov4), 32'd0);

        // Reset with skid full: everything discarded
        or4 = 1'b0; iv4 = 1'b1; sel4 = 2'd3;
        tick(); sel4 = 2'd2;
        tick(); chk("mr_ir_full", 32'(ir4), 32'd0);
        rst = 1'b1; iv4 = 1'b0;
        tick(); chk("mr_ov", 32'(ov4), 32'd0); chk("mr_dout", dout4, 32'd0);
        chk("mr_ir", 32'(ir4), 32'd1);
        rst = 1'b0; or4 = 1'b1;
        tick(); chk("mr_post_ov0", 32'(ov4), 32'd0);
        tick(); chk("mr_post_ov1", 32'(ov4), 32'd0);

        // Random valid/ready against a queue model
        pend = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            if (!pend) begin
                iv4  = 1'($urandom_range(0, 1));
                sel4 = 2'($urandom_range(0, 3));
                for (int k = 0; k < 4; k++) din4[k*32 +: 32] = $urandom;
            end
            or4 = 1'($urandom_range(0, 1));
            acc = iv4 && ir4;
            emi = ov4 && or4;
            if (emi) begin
                chk("rnd_q_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("rnd_data", dout4, q[0]);
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back(din4[sel4*32 +: 32]);
            pend       = iv4 && !acc;
            prev_stall = ov4 && !or4;
            prev_dout  = dout4;
            tick();
            if (prev_stall) begin
                chk("rnd_hold_ov", 32'(ov4), 32'd1);
                chk("rnd_hold_dout", dout4, prev_dout);
            end
        end

        // Drain remaining beats
        iv4 = 1'b0; or4 = 1'b1;
        for (int n = 0; n < 4; n++) begin
            if (ov4) begin
                chk("drn_q_nonempty", 32'(q.size() != 0), 32'd1);
                if (q.size() != 0) begin
                    chk("drn_data", dout4, q[0]);
                    void'(q.pop_front());
                end
            end
            tick();
        end
        chk("drn_q_empty", 32'(q.size()), 32'd0);
        chk("drn_ov", 32'(ov4), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
